int_sync_crossing_sink_n: RTL and testbench

//   Parametrised interrupt sync-crossing sink: receives NUM_INT interrupt lines from a source clock

---
 rtl/int_sync_crossing_sink_n.sv | 116 +++++++++++
 tb/tb_int_sync_crossing_sink_n.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sync_crossing_sink_n.sv
//------------------------------------------------------------------------------
// int_sync_crossing_sink_n
//
// Interrupt sync-crossing sink. Receives NUM_INT interrupt lines from a source
// clock domain, resynchronises each one through its own single-bit flop chain
// into the local clock domain, and hands the result to the interrupt fabric.
// Each channel is either level (output follows the synchronised input) or
// rising-edge (a rising edge sets a pending bit that stays set until it is
// cleared by edge_clr).
//
// Parameters
//   NUM_INT      number of interrupt channels (1..32)
//   SYNC_STAGES  synchroniser depth (0..4); 0 means the input is already in
//                the local domain and is used combinationally
//   EDGE_MASK    bit i = 1 -> channel i is rising-edge/pending, 0 -> level
//
// Ports
//   clock         in   local clock
//   reset         in   asynchronous active-low reset (0 = in reset)
//   auto_in_sync  in   raw interrupt lines from the source domain
//   edge_clr      in   per-channel pending clear pulse (edge channels only)
//   auto_out      out  delivered interrupts (forced to 0 while in reset)
//   auto_out_any  out  OR of auto_out
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module int_sync_crossing_sink_n #(
    parameter int                 NUM_INT     = 2,
    parameter int                 SYNC_STAGES = 3,
    parameter logic [NUM_INT-1:0] EDGE_MASK   = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_INT-1:0] auto_in_sync,
    input  logic [NUM_INT-1:0] edge_clr,
    output logic [NUM_INT-1:0] auto_out,
    output logic               auto_out_any
);

    generate
        if ((NUM_INT < 1) || (NUM_INT > 32) || (SYNC_STAGES < 0) || (SYNC_STAGES > 4)) begin : g_param_check
            $fatal(1, "int_sync_crossing_sink_n: NUM_INT must be 1..32 and SYNC_STAGES 0..4");
        end
    endgenerate

    logic [NUM_INT-1:0] sync_s;   // input as seen in the local domain
    logic [NUM_INT-1:0] rise_s;   // rising edge detected this cycle
    logic [NUM_INT-1:0] prev_d;
    logic [NUM_INT-1:0] prev_q;   // last cycle's synchronised value (edge channels)
    logic [NUM_INT-1:0] pend_d;
    logic [NUM_INT-1:0] pend_q;   // pending bits (edge channels)
    logic [NUM_INT-1:0] out_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_s = auto_in_sync;
        end else begin : g_chain
            // Plain shift chain: no logic between stages, one independent bit per channel.
            logic [NUM_INT-1:0] sync_q [SYNC_STAGES];

            // Synchroniser flops, cleared asynchronously.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= auto_in_sync;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Edge detection and pending next-state; a new rise beats a clear in the same cycle.
    always_comb begin
        rise_s = '0;
        pend_d = '0;
        prev_d = '0;
        rise_s = sync_s & ~prev_q;
        pend_d = (rise_s | (pend_q & ~edge_clr)) & EDGE_MASK;
        prev_d = sync_s & EDGE_MASK;
    end

    // Edge-channel state. prev clears to 0 so an input already high at reset
    // release produces exactly one pending event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    // Output mux. The reset gate matters only for the zero-stage level path,
    // where the raw input would otherwise leak through during reset.
    always_comb begin
        out_s        = '0;
        auto_out     = '0;
        auto_out_any = 1'b0;
        out_s        = (sync_s & ~EDGE_MASK) | pend_q;
        if (reset) begin
            auto_out = out_s;
        end else begin
            auto_out = '0;
        end
        auto_out_any = |auto_out;
    end

endmodule

// File: tb/tb_int_sync_crossing_sink_n.sv
`timescale 1ns/1ps

module tb_int_sync_crossing_sink_n;

    // Three configurations: A = 3 stages mixed level/edge, B = 0 stages,
    // C = 2 stages with edge on channel 0.
    localparam int          ND     = 3;
    localparam logic [31:0] MASK_A = 32'h0000_000A;
    localparam logic [31:0] MASK_B = 32'h0000_0002;
    localparam logic [31:0] MASK_C = 32'h0000_0001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in_a  = 4'd0, clr_a = 4'd0;
    logic [1:0] in_b  = 2'd0, clr_b = 2'd0;
    logic [1:0] in_c  = 2'd0, clr_c = 2'd0;
    logic [3:0] out_a;
    logic [1:0] out_b, out_c;
    logic       any_a, any_b, any_c;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    int_sync_crossing_sink_n #(.NUM_INT(4), .SYNC_STAGES(3), .EDGE_MASK(4'b1010)) u_dut_a (
        .clock(clock), .reset(reset), .auto_in_sync(in_a), .edge_clr(clr_a),
        .auto_out(out_a), .auto_out_any(any_a));

    int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(0), .EDGE_MASK(2'b10)) u_dut_b (
        .clock(clock), .reset(reset), .auto_in_sync(in_b), .edge_clr(clr_b),
        .auto_out(out_b), .auto_out_any(any_b));

    int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(2), .EDGE_MASK(2'b01)) u_dut_c (
        .clock(clock), .reset(reset), .auto_in_sync(in_c), .edge_clr(clr_c),
        .auto_out(out_c), .auto_out_any(any_c));

    // ---------------- reference model ----------------
    // samp[d][k] = input value captured k+1 edges ago; last_s = synchronised
    // value seen at the previous edge; pend = pending events.
    logic [31:0] m_samp [ND][5];
    logic [31:0] m_last_s [ND];
    logic [31:0] m_pend [ND];

    function automatic int ss_of(int d);
        case (d)
            0:       return 3;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(int d);
        case (d)
            0:       return MASK_A;
            1:       return MASK_B;
            default: return MASK_C;
        endcase
    endfunction

    function automatic logic [31:0] wmask_of(int d);
        case (d)
            0:       return 32'h0000_000F;
            default: return 32'h0000_0003;
        endcase
    endfunction

    function automatic logic [31:0] cur_in(int d);
        case (d)
            0:       return {28'd0, in_a};
            1:       return {30'd0, in_b};
            default: return {30'd0, in_c};
        endcase
    endfunction

    function automatic logic [31:0] cur_clr(int d);
        case (d)
            0:       return {28'd0, clr_a};
            1:       return {30'd0, clr_b};
            default: return {30'd0, clr_c};
        endcase
    endfunction

    function automatic logic [31:0] cur_out(int d);
        case (d)
            0:       return {28'd0, out_a};
            1:       return {30'd0, out_b};
            default: return {30'd0, out_c};
        endcase
    endfunction

    function automatic logic cur_any(int d);
        case (d)
            0:       return any_a;
            1:       return any_b;
            default: return any_c;
        endcase
    endfunction

    // Input as seen in the local domain: delayed by SYNC_STAGES edges, or live for 0.
    function automatic logic [31:0] m_s(int d);
        if (ss_of(d) == 0) return cur_in(d);
        return m_samp[d][ss_of(d)-1];
    endfunction

    function automatic logic [31:0] m_exp(int d);
        if (!reset) return 32'd0;
        return ((m_s(d) & ~mask_of(d)) | m_pend[d]) & wmask_of(d);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 5; k++) m_samp[d][k] = 32'd0;
            m_last_s[d] = 32'd0;
            m_pend[d]   = 32'd0;
        end
    endtask

    // One local clock edge: detect rises, apply clears (set wins), then advance history.
    task automatic m_edge();
        logic [31:0] s_now, rise;
        for (int d = 0; d < ND; d++) begin
            s_now       = m_s(d);
            rise        = s_now & ~m_last_s[d];
            m_pend[d]   = (rise | (m_pend[d] & ~cur_clr(d))) & mask_of(d);
            m_last_s[d] = s_now;
            for (int k = 4; k > 0; k--) m_samp[d][k] = m_samp[d][k-1];
            m_samp[d][0] = cur_in(d);
        end
    endtask

    // Advance one cycle; inputs are driven at negedge, outputs sampled at negedge.
    task automatic tick();
        @(posedge clock);
        if (reset) m_edge();
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        m_reset();
        in_a = 4'hF; in_b = 2'b11; in_c = 2'b11;
        repeat (3) @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (cur_out(d) !== 32'd0) begin
                failures++;
                $display("FAIL reset_out dut%0d got=%h want=0", d, cur_out(d));
            end
            checks++;
            if (cur_any(d) !== 1'b0) begin
                failures++;
                $display("FAIL reset_any dut%0d got=%b want=0", d, cur_any(d));
            end
        end
        in_a = 4'd0; in_b = 2'd0; in_c = 2'd0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_level_latency();
        logic e;
        in_a[0] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            e = (c >= 3) && (c < 13);
            checks++;
            if (out_a[0] !== e || any_a !== e) begin
                failures++;
                $display("FAIL level_latency c=%0d out0=%b any=%b want=%b", c, out_a[0], any_a, e);
            end
            checks++;
            if (cur_out(0) !== m_exp(0)) begin
                failures++;
                $display("FAIL level_model c=%0d got=%h want=%h", c, cur_out(0), m_exp(0));
            end
            if (c == 10) in_a[0] = 1'b0;
        end
    endtask

    task automatic test_edge_clear();
        logic e;
        in_c[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            e = (c >= 3) && (c < 9);
            checks++;
            if (out_c[0] !== e || any_c !== e) begin
                failures++;
                $display("FAIL edge_clear c=%0d out0=%b any=%b want=%b", c, out_c[0], any_c, e);
            end
            if (c == 5) in_c[0] = 1'b0;
            clr_c[0] = (c == 8);
        end
    endtask

    task automatic test_collision();
        logic e;
        in_c[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            e = (c == 3) || (c == 4);
            checks++;
            if (out_c[0] !== e) begin
                failures++;
                $display("FAIL collision c=%0d out0=%b want=%b", c, out_c[0], e);
            end
            clr_c[0] = (c == 2) || (c == 4);
        end
        in_c[0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_comb_bypass();
        #1 in_b[0] = 1'b1;
        #1;
        checks++;
        if (out_b !== 2'b01 || any_b !== 1'b1) begin
            failures++;
            $display("FAIL comb_rise out=%b any=%b want=01/1", out_b, any_b);
        end
        #1 in_b[0] = 1'b0;
        #1;
        checks++;
        if (out_b !== 2'b00 || any_b !== 1'b0) begin
            failures++;
            $display("FAIL comb_fall out=%b any=%b want=00/0", out_b, any_b);
        end
        tick();
        checks++;
        if (cur_out(1) !== m_exp(1)) begin
            failures++;
            $display("FAIL comb_model got=%h want=%h", cur_out(1), m_exp(1));
        end
    endtask

    task automatic test_reset_mid();
        in_a = 4'b1111;
        repeat (6) tick();
        checks++;
        if (out_a !== 4'b1111) begin
            failures++;
            $display("FAIL mid_before got=%b want=1111", out_a);
        end
        #2 reset = 1'b0;
        m_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (cur_out(d) !== 32'd0 || cur_any(d) !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset dut%0d out=%h any=%b want=0", d, cur_out(d), cur_any(d));
            end
        end
        in_a = 4'd0;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (out_a !== 4'd0 || cur_out(0) !== m_exp(0)) begin
                failures++;
                $display("FAIL mid_after c=%0d got=%b want=0000", c, out_a);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic e;
        reset = 1'b0;
        m_reset();
        in_a = 4'b0010;
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            e = (c >= 4) && (c < 8);
            checks++;
            if (out_a !== {2'b00, e, 1'b0}) begin
                failures++;
                $display("FAIL held_reset c=%0d got=%b want=%b", c, out_a, {2'b00, e, 1'b0});
            end
            clr_a[1] = (c == 7);
        end
        in_a = 4'd0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_a  = 4'($urandom);
            in_b  = 2'($urandom);
            in_c  = 2'($urandom);
            clr_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            clr_b = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            clr_c = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (cur_out(d) !== m_exp(d) || cur_any(d) !== (|m_exp(d))) begin
                    failures++;
                    $display("FAIL random n=%0d dut%0d out=%h any=%b want=%h", n, d, cur_out(d), cur_any(d), m_exp(d));
                end
            end
        end
        in_a = 4'd0; in_b = 2'd0; in_c = 2'd0;
        clr_a = 4'd0; clr_b = 2'd0; clr_c = 2'd0;
    endtask

    initial begin
        test_reset();
        test_level_latency();
        test_edge_clear();
        test_collision();
        test_comb_bypass();
        test_reset_mid();
        test_held_through_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
